can_bit_timing: RTL



---
 rtl/can_bit_timing.sv | 218 +++++++++++++++++++++
 1 files changed

// File: rtl/can_bit_timing.sv
// can_bit_timing: per-channel CAN bit timing unit.
// Synchronises the RX pin, divides the clock into time quanta, walks each
// bit through SYNC_SEG / TSEG1 / TSEG2, applies hard sync and SJW-limited
// resynchronisation, samples the bus at the end of TSEG1 and requests the
// next TX bit from the protocol engine at the end of every bit.
module can_bit_timing #(
    parameter int BRP_W   = 8,
    parameter int TSEG1_W = 4,
    parameter int TSEG2_W = 3
) (
    input  logic               i_clk,
    input  logic               i_rstn,
    input  logic               i_enable,
    input  logic [BRP_W-1:0]   i_brp,
    input  logic [TSEG1_W-1:0] i_tseg1,
    input  logic [TSEG2_W-1:0] i_tseg2,
    input  logic [1:0]         i_sjw,
    input  logic               i_hard_sync_en,
    input  logic               i_can_rx,
    input  logic               i_tx_bit,
    output logic               o_can_tx,
    output logic               o_tx_req,
    output logic               o_sample_valid,
    output logic               o_sample_bit
);

    // Segment counter must hold TSEG1 plus the largest extension (4 quanta).
    localparam int SEG_W = ((TSEG1_W > TSEG2_W) ? TSEG1_W : TSEG2_W) + 2;
    localparam logic [SEG_W-1:0] SEG_ONE = SEG_W'(1'b1);
    localparam logic [BRP_W-1:0] BRP_ONE = BRP_W'(1'b1);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SYNC  = 2'd1,
        ST_TSEG1 = 2'd2,
        ST_TSEG2 = 2'd3
    } state_e;

    state_e             state_q;
    logic               sync1_q, sync2_q, prev_q;
    logic [BRP_W-1:0]   presc_q;
    logic [SEG_W-1:0]   seg_q;
    logic [2:0]         ext_q, shr_q;
    logic               resync_done_q;
    logic [BRP_W-1:0]   brp_q;
    logic [TSEG1_W-1:0] tseg1_q;
    logic [TSEG2_W-1:0] tseg2_q;
    logic [1:0]         sjw_q;

    logic               fall_s, tick_s;
    logic [2:0]         sjw1_s;
    logic               hard_s, early_s, resync_set_s;
    logic [2:0]         ext_d, shr_d;
    logic               tseg1_end_s, tseg2_end_s;

    assign fall_s = prev_q & ~sync2_q;
    assign tick_s = (presc_q == brp_q);
    assign sjw1_s = {1'b0, sjw_q} + 3'd1;

    // Classify a falling edge (hard sync / late / early resync) and find segment ends.
    always_comb begin
        hard_s       = 1'b0;
        early_s      = 1'b0;
        resync_set_s = 1'b0;
        ext_d        = ext_q;
        shr_d        = shr_q;
        if (fall_s && (state_q != ST_IDLE) && i_enable) begin
            if (i_hard_sync_en) begin
                hard_s = 1'b1;
            end else if (!resync_done_q && o_can_tx) begin
                case (state_q)
                    ST_TSEG1: begin
                        resync_set_s = 1'b1;
                        if (seg_q < SEG_W'(sjw1_s)) begin
                            ext_d = seg_q[2:0] + 3'd1;
                        end else begin
                            ext_d = sjw1_s;
                        end
                    end
                    ST_TSEG2: begin
                        // Remaining quanta (tseg2+1-q) within SJW: end the bit now.
                        if ((SEG_W'(tseg2_q) + SEG_ONE) <= (seg_q + SEG_W'(sjw1_s))) begin
                            early_s = 1'b1;
                        end else begin
                            shr_d        = sjw1_s;
                            resync_set_s = 1'b1;
                        end
                    end
                    default: begin
                        resync_set_s = 1'b0;
                    end
                endcase
            end else begin
                resync_set_s = 1'b0;
            end
        end else begin
            hard_s = 1'b0;
        end
        tseg1_end_s = tick_s && (state_q == ST_TSEG1) &&
                      (seg_q >= (SEG_W'(tseg1_q) + SEG_W'(ext_d)));
        tseg2_end_s = tick_s && (state_q == ST_TSEG2) &&
                      ((seg_q + SEG_W'(shr_d)) >= SEG_W'(tseg2_q));
    end

    // RX synchroniser, prescaler, segment state machine and registered outputs.
    always_ff @(posedge i_clk or negedge i_rstn) begin
        if (!i_rstn) begin
            sync1_q        <= 1'b1;
            sync2_q        <= 1'b1;
            prev_q         <= 1'b1;
            state_q        <= ST_IDLE;
            presc_q        <= '0;
            seg_q          <= '0;
            ext_q          <= 3'd0;
            shr_q          <= 3'd0;
            resync_done_q  <= 1'b0;
            brp_q          <= '0;
            tseg1_q        <= '0;
            tseg2_q        <= '0;
            sjw_q          <= 2'd0;
            o_can_tx       <= 1'b1;
            o_tx_req       <= 1'b0;
            o_sample_valid <= 1'b0;
            o_sample_bit   <= 1'b1;
        end else begin
            sync1_q        <= i_can_rx;
            sync2_q        <= sync1_q;
            prev_q         <= sync2_q;
            o_tx_req       <= 1'b0;
            o_sample_valid <= 1'b0;
            // The engine presents the new bit while o_tx_req is high.
            if (o_tx_req) begin
                o_can_tx <= i_tx_bit;
            end
            case (state_q)
                ST_IDLE: begin
                    o_can_tx      <= 1'b1;
                    presc_q       <= '0;
                    seg_q         <= '0;
                    ext_q         <= 3'd0;
                    shr_q         <= 3'd0;
                    resync_done_q <= 1'b0;
                    brp_q         <= i_brp;
                    tseg1_q       <= i_tseg1;
                    tseg2_q       <= i_tseg2;
                    sjw_q         <= i_sjw;
                    if (i_enable) begin
                        state_q  <= ST_SYNC;
                        o_tx_req <= 1'b1;
                    end
                end
                default: begin
                    if (!i_enable) begin
                        state_q       <= ST_IDLE;
                        o_can_tx      <= 1'b1;
                        presc_q       <= '0;
                        seg_q         <= '0;
                        ext_q         <= 3'd0;
                        shr_q         <= 3'd0;
                        resync_done_q <= 1'b0;
                    end else if (hard_s || early_s) begin
                        // Restart the bit; only an early resync ends a bit toward the engine.
                        state_q       <= ST_SYNC;
                        presc_q       <= '0;
                        seg_q         <= '0;
                        ext_q         <= 3'd0;
                        shr_q         <= 3'd0;
                        resync_done_q <= 1'b0;
                        o_tx_req      <= early_s;
                    end else begin
                        ext_q <= ext_d;
                        shr_q <= shr_d;
                        if (resync_set_s) begin
                            resync_done_q <= 1'b1;
                        end
                        if (tick_s) begin
                            presc_q <= '0;
                            case (state_q)
                                ST_SYNC: begin
                                    state_q <= ST_TSEG1;
                                    seg_q   <= '0;
                                end
                                ST_TSEG1: begin
                                    if (tseg1_end_s) begin
                                        state_q        <= ST_TSEG2;
                                        seg_q          <= '0;
                                        o_sample_valid <= 1'b1;
                                        o_sample_bit   <= sync2_q;
                                    end else begin
                                        seg_q <= seg_q + SEG_ONE;
                                    end
                                end
                                ST_TSEG2: begin
                                    if (tseg2_end_s) begin
                                        state_q       <= ST_SYNC;
                                        seg_q         <= '0;
                                        ext_q         <= 3'd0;
                                        shr_q         <= 3'd0;
                                        resync_done_q <= 1'b0;
                                        o_tx_req      <= 1'b1;
                                    end else begin
                                        seg_q <= seg_q + SEG_ONE;
                                    end
                                end
                                default: begin
                                    state_q <= ST_IDLE;
                                end
                            endcase
                        end else begin
                            presc_q <= presc_q + BRP_ONE;
                        end
                    end
                end
            endcase
        end
    end

endmodule
